// File: rtl/branch_tag_manager_pkg.sv
// Shared types and defaults for the branch tag manager slice.
// Also supplies the codebase-wide ROB tag width and boolean macros if not already defined.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

package br_pkg;

   localparam int unsigned BR_NUM_DEF   = 4;
   localparam int unsigned BR_TAG_W_DEF = $clog2(BR_NUM_DEF);

   typedef enum logic {
      NORMAL  = 1'b0,
      RECOVER = 1'b1
   } br_state_e;

endpackage

// File: rtl/branch_tag_manager_age_matrix.sv
// Relative-age tracking for live branch slots: older[i][j]=1 means slot i is older than slot j.
// Exposes the row of a queried slot, i.e. the set of slots younger than it.
module br_age_matrix
   import br_pkg::*;
#(
   parameter int unsigned NUM_BR   = BR_NUM_DEF,
   parameter int unsigned BR_TAG_W = $clog2(NUM_BR)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                alloc_en,
   input  logic [BR_TAG_W-1:0] alloc_idx,
   input  logic [NUM_BR-1:0]   valid_post,
   input  logic [NUM_BR-1:0]   free_vec,
   input  logic [BR_TAG_W-1:0] query_tag,
   output logic [NUM_BR-1:0]   younger_mask
);

   logic [NUM_BR-1:0][NUM_BR-1:0] older;
   logic [NUM_BR-1:0][NUM_BR-1:0] older_d;

   // Frees clear first; the new slot then becomes younger than every slot still live after the free.
   always_comb begin
      older_d = older;
      for (int unsigned i = 0; i < NUM_BR; i++) begin
         for (int unsigned j = 0; j < NUM_BR; j++) begin
            if (free_vec[i] || free_vec[j]) begin
               older_d[i][j] = `FALSE;
            end
         end
      end
      if (alloc_en) begin
         for (int unsigned k = 0; k < NUM_BR; k++) begin
            older_d[k][alloc_idx] = valid_post[k];
            older_d[alloc_idx][k] = `FALSE;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         older <= '0;
      end else begin
         older <= older_d;
      end
   end

   assign younger_mask = older[query_tag];

endmodule

// File: rtl/branch_tag_manager.sv
// Branch tag allocator and resolution sequencer for up to NUM_BR in-flight branches.
// Mispredictions squash younger branches and hold a fixed recovery window.
module branch_tag_manager
   import br_pkg::*;
#(
   parameter int unsigned NUM_BR         = BR_NUM_DEF,
   parameter int unsigned BR_TAG_W       = $clog2(NUM_BR),
   parameter int unsigned RECOVER_CYCLES = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    alloc_req,
   input  logic [`ROB_TAG_LEN-1:0] alloc_rob_tag,
   output logic                    alloc_grant,
   output logic [BR_TAG_W-1:0]     alloc_tag,
   output logic                    full,
   input  logic                    resolve_valid,
   input  logic [BR_TAG_W-1:0]     resolve_tag,
   input  logic                    resolve_taken,
   output logic                    resolve_ready,
   output logic                    resolve,
   output logic                    kill,
   output logic [BR_TAG_W-1:0]     out_tag,
   output logic [`ROB_TAG_LEN-1:0] out_rob_tag,
   output logic [NUM_BR-1:0]       squash_mask,
   output logic                    busy
);

   localparam int unsigned CNT_W = $clog2(RECOVER_CYCLES + 1);

   br_state_e                 state, state_d;
   logic [CNT_W-1:0]          cnt, cnt_d;
   logic [NUM_BR-1:0]         valid, valid_post, valid_d;
   logic [`ROB_TAG_LEN-1:0]   rob_tag_q [NUM_BR];
   logic [NUM_BR-1:0]         younger, squash, free_vec, alloc_onehot;
   logic                      res_acc, kill_acc;

   assign full          = &valid;
   assign busy          = (state == RECOVER);
   assign resolve_ready = (state == NORMAL);

   assign res_acc     = resolve_valid & resolve_ready & valid[resolve_tag];
   assign kill_acc    = res_acc & resolve_taken;
   assign alloc_grant = alloc_req & ~full & (state == NORMAL) & ~kill_acc;

   always_comb begin
      alloc_tag = '0;
      for (int unsigned i = NUM_BR; i > 0; i--) begin
         if (!valid[i-1]) begin
            alloc_tag = BR_TAG_W'(i - 1);
         end
      end
   end

   assign squash       = valid & younger;
   assign free_vec     = res_acc ? ((NUM_BR'(1) << resolve_tag) | (resolve_taken ? squash : '0)) : '0;
   assign valid_post   = valid & ~free_vec;
   assign alloc_onehot = alloc_grant ? (NUM_BR'(1) << alloc_tag) : '0;
   assign valid_d      = valid_post | alloc_onehot;

   br_age_matrix #(
      .NUM_BR   (NUM_BR),
      .BR_TAG_W (BR_TAG_W)
   ) u_age (
      .clock        (clock),
      .reset        (reset),
      .alloc_en     (alloc_grant),
      .alloc_idx    (alloc_tag),
      .valid_post   (valid_post),
      .free_vec     (free_vec),
      .query_tag    (resolve_tag),
      .younger_mask (younger)
   );

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         NORMAL: begin
            if (kill_acc) begin
               state_d = RECOVER;
               cnt_d   = CNT_W'(RECOVER_CYCLES - 1);
            end
         end
         RECOVER: begin
            if (cnt == '0) begin
               state_d = NORMAL;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= NORMAL;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid       <= '0;
         resolve     <= `FALSE;
         kill        <= `FALSE;
         out_tag     <= '0;
         out_rob_tag <= '0;
         squash_mask <= '0;
         for (int unsigned i = 0; i < NUM_BR; i++) begin
            rob_tag_q[i] <= '0;
         end
      end else begin
         valid   <= valid_d;
         resolve <= res_acc & ~resolve_taken;
         kill    <= kill_acc;
         if (alloc_grant) begin
            rob_tag_q[alloc_tag] <= alloc_rob_tag;
         end
         if (res_acc) begin
            out_tag     <= resolve_tag;
            out_rob_tag <= rob_tag_q[resolve_tag];
         end
         squash_mask <= kill_acc ? squash : '0;
      end
   end

endmodule

// File: tb/tb_branch_tag_manager.sv
// Directed bench for branch_tag_manager: stimulus pushes expected pulses, a monitor pops and compares.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_branch_tag_manager;

   localparam int RW = `ROB_TAG_LEN;

   logic          clock = 1'b0;
   logic          reset;
   logic          alloc_req;
   logic [RW-1:0] alloc_rob_tag;
   logic          alloc_grant;
   logic [1:0]    alloc_tag;
   logic          full;
   logic          resolve_valid;
   logic [1:0]    resolve_tag;
   logic          resolve_taken;
   logic          resolve_ready;
   logic          resolve;
   logic          kill;
   logic [1:0]    out_tag;
   logic [RW-1:0] out_rob_tag;
   logic [3:0]    squash_mask;
   logic          busy;

   typedef struct packed {
      logic          is_kill;
      logic [1:0]    tag;
      logic [RW-1:0] rob;
      logic [3:0]    mask;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clock = ~clock;

   branch_tag_manager #(
      .NUM_BR         (4),
      .RECOVER_CYCLES (2)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .alloc_req     (alloc_req),
      .alloc_rob_tag (alloc_rob_tag),
      .alloc_grant   (alloc_grant),
      .alloc_tag     (alloc_tag),
      .full          (full),
      .resolve_valid (resolve_valid),
      .resolve_tag   (resolve_tag),
      .resolve_taken (resolve_taken),
      .resolve_ready (resolve_ready),
      .resolve       (resolve),
      .kill          (kill),
      .out_tag       (out_tag),
      .out_rob_tag   (out_rob_tag),
      .squash_mask   (squash_mask),
      .busy          (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      exp_t a;
      exp_t e;
      if (!reset && (resolve || kill)) begin
         a = '{kill, out_tag, out_rob_tag, (kill ? squash_mask : 4'b0000)};
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse: got resolve=%b kill=%b tag=%0d rob=%0d, expected no pulse",
                     resolve, kill, out_tag, out_rob_tag);
         end else begin
            e = sb.pop_front();
            if (a !== e || (resolve && kill)) begin
               n_bad++;
               $display("FAIL pulse: got resolve=%b kill=%b tag=%0d rob=%0d mask=%b, expected kill=%b tag=%0d rob=%0d mask=%b",
                        resolve, kill, a.tag, a.rob, a.mask, e.is_kill, e.tag, e.rob, e.mask);
            end
         end
      end
   end

   task automatic clear_inputs();
      alloc_req     = 1'b0;
      alloc_rob_tag = '0;
      resolve_valid = 1'b0;
      resolve_tag   = '0;
      resolve_taken = 1'b0;
   endtask

   task automatic do_alloc(input logic [RW-1:0] rob, input logic exp_g, input logic [1:0] exp_tag);
      alloc_req     = 1'b1;
      alloc_rob_tag = rob;
      #1;
      chk("alloc_grant", alloc_grant, exp_g);
      if (exp_g) chk("alloc_tag", alloc_tag, exp_tag);
      @(negedge clock);
      clear_inputs();
      #1;
   endtask

   task automatic do_resolve(input logic [1:0] tag, input logic taken, input logic acc,
                             input logic [RW-1:0] rob, input logic [3:0] mask);
      resolve_valid = 1'b1;
      resolve_tag   = tag;
      resolve_taken = taken;
      #1;
      chk("resolve_ready", resolve_ready, 1);
      if (acc) sb.push_back('{taken, tag, rob, mask});
      @(negedge clock);
      clear_inputs();
      #1;
      chk("pulse_latency", sb.size(), 0);
   endtask

   task automatic do_both(input logic [RW-1:0] arob, input logic [1:0] tag,
                          input logic [RW-1:0] rob, input logic [3:0] mask);
      alloc_req     = 1'b1;
      alloc_rob_tag = arob;
      resolve_valid = 1'b1;
      resolve_tag   = tag;
      resolve_taken = 1'b1;
      #1;
      chk("alloc_grant_vs_kill", alloc_grant, 0);
      sb.push_back('{1'b1, tag, rob, mask});
      @(negedge clock);
      clear_inputs();
      #1;
      chk("pulse_latency", sb.size(), 0);
   endtask

   task automatic recover_cycle();
      alloc_req     = 1'b1;
      alloc_rob_tag = 7;
      resolve_valid = 1'b1;
      resolve_tag   = 2'd0;
      resolve_taken = 1'b0;
      #1;
      chk("recover_busy", busy, 1);
      chk("recover_ready", resolve_ready, 0);
      chk("recover_alloc", alloc_grant, 0);
      @(negedge clock);
      clear_inputs();
      #1;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_full", full, 0);
      chk("rst_busy", busy, 0);
      chk("rst_resolve", resolve, 0);
      chk("rst_kill", kill, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_out_rob", out_rob_tag, 0);
      chk("rst_mask", squash_mask, 0);
      chk("rst_ready", resolve_ready, 1);

      do_alloc(5, 1, 0);
      do_resolve(0, 0, 1, 5, 4'b0000);

      do_alloc(1, 1, 0);
      do_alloc(2, 1, 1);
      do_alloc(3, 1, 2);
      do_alloc(4, 1, 3);
      chk("full_after_4", full, 1);
      do_alloc(8, 0, 0);

      do_resolve(1, 0, 1, 2, 4'b0000);
      chk("full_after_free", full, 0);
      do_alloc(9, 1, 1);
      chk("full_refill", full, 1);
      // Age order now 0,2,3,1: only slot 1 is younger than slot 3.
      do_resolve(3, 1, 1, 4, 4'b0010);
      recover_cycle();
      recover_cycle();
      chk("recover_done_busy", busy, 0);
      chk("recover_done_ready", resolve_ready, 1);

      do_resolve(2, 0, 1, 3, 4'b0000);
      do_alloc(11, 1, 1);
      do_alloc(12, 1, 2);
      do_alloc(13, 1, 3);
      do_resolve(1, 1, 1, 11, 4'b1100);
      recover_cycle();
      recover_cycle();
      chk("recover2_done_busy", busy, 0);
      do_alloc(21, 1, 1);
      do_alloc(22, 1, 2);
      do_alloc(23, 1, 3);
      chk("full_after_refill", full, 1);

      do_resolve(3, 0, 1, 23, 4'b0000);
      do_both(30, 0, 1, 4'b0110);
      recover_cycle();
      recover_cycle();

      do_alloc(40, 1, 0);
      do_alloc(41, 1, 1);
      do_alloc(42, 1, 2);
      do_resolve(2, 1, 1, 42, 4'b0000);
      chk("busy_before_reset", busy, 1);
      reset = 1'b1;
      #1;
      chk("midrec_busy", busy, 0);
      chk("midrec_kill", kill, 0);
      chk("midrec_full", full, 0);
      chk("midrec_ready", resolve_ready, 1);
      chk("midrec_mask", squash_mask, 0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      do_resolve(2, 0, 0, 0, 4'b0000);
      do_resolve(1, 1, 0, 0, 4'b0000);
      chk("invalid_no_busy", busy, 0);
      do_alloc(50, 1, 0);

      repeat (3) @(negedge clock);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
